// File: rtl/store_data_packer.sv
// store_data_packer: narrows register values onto byte lanes, splitting misaligned stores into two word accesses
module store_data_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err,
    output logic        st_ovf
);
    typedef enum logic [1:0] {IDLE, REQ1, REQ2} state_t;
    state_t state, state_nx;
    logic [31:0] a_q, d_q;
    logic [1:0]  sz_q;
    logic        accept, split, fin, ovf;
    logic [1:0]  o;
    logic [4:0]  sh;
    logic [3:0]  m;
    logic [31:0] v;
    assign accept = st_valid && st_ready;
    assign o      = a_q[1:0];
    assign sh     = {o, 3'b000};
    assign split  = (sz_q == 2'd1 && o == 2'd3) || (sz_q == 2'd2 && o != 2'd0);
    assign fin    = mem_ack && (state == REQ2 || (state == REQ1 && !split));
    assign m      = sz_q == 2'd0 ? 4'b0001 : sz_q == 2'd1 ? 4'b0011 : 4'b1111;
    assign v      = sz_q == 2'd0 ? {24'd0, d_q[7:0]} : sz_q == 2'd1 ? {16'd0, d_q[15:0]} : d_q;
    assign ovf    = sz_q == 2'd0 ? !(&d_q[31:7] || ~|d_q[31:7]) :
                    sz_q == 2'd1 ? !(&d_q[31:15] || ~|d_q[31:15]) : 1'b0;
    // State register; reset abandons any store in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // Next-state: illegal sizes are accepted but never leave IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (accept && st_size != 2'd3) ? REQ1 : IDLE;
            REQ1:    state_nx = mem_ack ? (split ? REQ2 : IDLE) : REQ1;
            default: state_nx = mem_ack ? IDLE : REQ2;
        endcase
    end
    // Outputs decoded from state and the latched request; idle drives zeros
    always_comb begin
        st_ready  = state == IDLE;
        mem_req   = state != IDLE;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        if (state == REQ1) begin
            mem_addr  = {a_q[31:2], 2'b00};
            mem_be    = m << o;
            mem_wdata = sz_q == 2'd0 ? {4{d_q[7:0]}} : v << sh;
        end else if (state == REQ2) begin
            mem_addr  = {a_q[31:2] + 30'd1, 2'b00};
            mem_be    = m >> (3'd4 - {1'b0, o});
            mem_wdata = v >> (6'd32 - {1'b0, sh});
        end
    end
    // Capture the request at the accept edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_q  <= 32'd0;
            d_q  <= 32'd0;
            sz_q <= 2'd0;
        end else if (accept) begin
            a_q  <= st_addr;
            d_q  <= st_data;
            sz_q <= st_size;
        end
    // Completion pulses: after the final ack, or one cycle after an illegal-size accept
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            st_ovf  <= 1'b0;
        end else begin
            st_done <= fin || (accept && st_size == 2'd3);
            st_err  <= accept && st_size == 2'd3;
            st_ovf  <= fin && ovf;
        end
endmodule

// File: tb/tb_store_data_packer.sv
// tb_store_data_packer: directed checks of lane placement, splitting, stalls, illegal size and reset abort
module tb_store_data_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic [1:0]  st_size = 2'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        st_done, st_err, st_ovf;
    int passed = 0;
    int total = 0;

    store_data_packer dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .st_done(st_done), .st_err(st_err), .st_ovf(st_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_be"}, 32'(mem_be), 32'(be));
        chk({tag, "_wdata"}, mem_wdata, wd);
        chk({tag, "_ready"}, 32'(st_ready), 32'd0);
    endtask

    task automatic finish_chk(input string tag, input logic ovf);
        chk({tag, "_done"}, 32'(st_done), 32'd1);
        chk({tag, "_err"}, 32'(st_err), 32'd0);
        chk({tag, "_ovf"}, 32'(st_ovf), 32'(ovf));
        chk({tag, "_ready"}, 32'(st_ready), 32'd1);
        chk({tag, "_req_low"}, 32'(mem_req), 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        tick();
        st_valid = 1'b0;
        st_addr  = 32'hx;
        st_data  = 32'hx;
        st_size  = 2'bx;
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_done", 32'(st_done), 32'd0);
        chk("rst_err", 32'(st_err), 32'd0);
        chk("rst_ovf", 32'(st_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        issue(32'h0000_1002, 32'hFFFF_FF80, 2'd0);
        access("byte", 32'h0000_1000, 4'b0100, 32'h8080_8080);
        tick();
        finish_chk("byte", 1'b0);
        issue(32'h0000_2003, 32'h0001_ABCD, 2'd1);
        access("half_a1", 32'h0000_2000, 4'b1000, 32'hCD00_0000);
        tick();
        access("half_a2", 32'h0000_2004, 4'b0001, 32'h0000_00AB);
        tick();
        finish_chk("half", 1'b1);
        issue(32'hFFFF_FFFE, 32'h1122_3344, 2'd2);
        access("word_a1", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
        tick();
        access("word_a2", 32'h0000_0000, 4'b0011, 32'h0000_1122);
        tick();
        finish_chk("word_wrap", 1'b0);
        mem_ack = 1'b0;
        issue(32'h0000_3000, 32'hDEAD_BEEF, 2'd2);
        for (int i = 0; i < 3; i++) begin
            access($sformatf("stall%0d", i), 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d_nodone", i), 32'(st_done), 32'd0);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        finish_chk("stall", 1'b0);
        issue(32'h0000_0040, 32'h1234_5678, 2'd3);
        chk("ill_req", 32'(mem_req), 32'd0);
        chk("ill_ready", 32'(st_ready), 32'd1);
        chk("ill_done", 32'(st_done), 32'd1);
        chk("ill_err", 32'(st_err), 32'd1);
        chk("ill_ovf", 32'(st_ovf), 32'd0);
        tick();
        chk("ill_done_pulse", 32'(st_done), 32'd0);
        chk("ill_req_after", 32'(mem_req), 32'd0);
        issue(32'h0000_4001, 32'hA5A5_A5A5, 2'd2);
        access("abort_a1", 32'h0000_4000, 4'b1110, 32'hA5A5_A500);
        tick();
        access("abort_a2", 32'h0000_4004, 4'b0001, 32'h0000_00A5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req_async", 32'(mem_req), 32'd0);
        chk("abort_ready", 32'(st_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("abort_nodone", 32'(st_done), 32'd0);
        issue(32'h0000_5003, 32'h0000_007F, 2'd0);
        access("post_byte", 32'h0000_5000, 4'b1000, 32'h7F7F_7F7F);
        tick();
        finish_chk("post_byte", 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
